// File: rtl/interp_sched.sv
// Sequencer for the shared plane-equation interpolator: walks one primitive
// through NUM_ATTR attributes x 32 tile rows, settling the interpolator before each row is offered.
module interp_sched #(
  parameter int NUM_ATTR    = 4,
  parameter int ATTR_SETTLE = 4,
  parameter int ROW_SETTLE  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     prim_valid,
  output logic                     prim_ready,
  input  logic signed [31:0]       FX1,
  input  logic signed [31:0]       FX2,
  input  logic signed [31:0]       FX3,
  input  logic signed [31:0]       FY1,
  input  logic signed [31:0]       FY2,
  input  logic signed [31:0]       FY3,
  input  logic [NUM_ATTR*96-1:0]   attr_fz,
  input  logic [5:0]               tile_x,
  input  logic [5:0]               tile_y,
  input  logic                     abort,
  output logic signed [31:0]       ip_fx1,
  output logic signed [31:0]       ip_fx2,
  output logic signed [31:0]       ip_fx3,
  output logic signed [31:0]       ip_fy1,
  output logic signed [31:0]       ip_fy2,
  output logic signed [31:0]       ip_fy3,
  output logic signed [31:0]       ip_fz1,
  output logic signed [31:0]       ip_fz2,
  output logic signed [31:0]       ip_fz3,
  output logic [10:0]              ip_x_ps,
  output logic [10:0]              ip_y_ps,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [2:0]               row_attr,
  output logic [4:0]               row_y,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, SETTLE, PRESENT} state_t;

  state_t                 state, state_nxt;
  logic [15:0]            count;
  logic [NUM_ATTR*96-1:0] fz_q;
  logic [5:0]             tile_y_q;
  logic [2:0]             next_attr;
  logic                   accept, handshake, last_row, last_attr;

  always_comb begin
    prim_ready = (state == IDLE);
    row_valid  = (state == PRESENT);
    busy       = (state != IDLE);
    accept     = prim_valid && prim_ready;
    handshake  = row_valid && row_ready;
    last_row   = (row_y == 5'd31);
    last_attr  = (row_attr == 3'(NUM_ATTR - 1));
    next_attr  = last_attr ? row_attr : 3'(row_attr + 3'd1);
    state_nxt  = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETTLE;
      SETTLE: begin
        if (abort)               state_nxt = IDLE;
        else if (count == 16'd1) state_nxt = PRESENT;
      end
      PRESENT: begin
        if (abort)                       state_nxt = IDLE;
        else if (handshake) begin
          if (last_row && last_attr)     state_nxt = IDLE;
          else if (last_row)             state_nxt = SETTLE;
          else if (ROW_SETTLE == 0)      state_nxt = PRESENT;
          else                           state_nxt = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The accept edge gets one extra settle cycle: operands become visible to
  // the interpolator only after this edge registers them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      fz_q     <= '0;
      tile_y_q <= '0;
      ip_fx1   <= '0;
      ip_fx2   <= '0;
      ip_fx3   <= '0;
      ip_fy1   <= '0;
      ip_fy2   <= '0;
      ip_fy3   <= '0;
      ip_fz1   <= '0;
      ip_fz2   <= '0;
      ip_fz3   <= '0;
      ip_x_ps  <= '0;
      ip_y_ps  <= '0;
      row_attr <= '0;
      row_y    <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        fz_q     <= attr_fz;
        tile_y_q <= tile_y;
        ip_fx1   <= FX1;
        ip_fx2   <= FX2;
        ip_fx3   <= FX3;
        ip_fy1   <= FY1;
        ip_fy2   <= FY2;
        ip_fy3   <= FY3;
        ip_fz1   <= attr_fz[31:0];
        ip_fz2   <= attr_fz[63:32];
        ip_fz3   <= attr_fz[95:64];
        ip_x_ps  <= {tile_x, 5'd0};
        ip_y_ps  <= {tile_y, 5'd0};
        row_attr <= '0;
        row_y    <= '0;
        count    <= 16'(ATTR_SETTLE + 1);
      end else if (state == SETTLE && !abort) begin
        count <= count - 16'd1;
      end else if (handshake && !abort) begin
        if (!last_row) begin
          row_y   <= 5'(row_y + 5'd1);
          ip_y_ps <= {tile_y_q, 5'(row_y + 5'd1)};
          count   <= 16'(ROW_SETTLE);
        end else if (!last_attr) begin
          row_y    <= '0;
          row_attr <= next_attr;
          ip_y_ps  <= {tile_y_q, 5'd0};
          ip_fz1   <= fz_q[int'(next_attr)*96 +: 32];
          ip_fz2   <= fz_q[int'(next_attr)*96 + 32 +: 32];
          ip_fz3   <= fz_q[int'(next_attr)*96 + 64 +: 32];
          count    <= 16'(ATTR_SETTLE);
        end else begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule
